// File: rtl/async_sram_ctrl.sv
// Front-end controller for an external asynchronous SRAM: valid/ready request port in,
// registered ce_n/we_n/oe_n/be_n strobes with setup/pulse/hold sequencing out.
module async_sram_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  wr_done,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic [DATA_W/8-1:0]   sram_be_n,
    output logic [DATA_W-1:0]     sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_in
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_WAIT,
        R_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              ready_q, ready_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic [BE_W-1:0]   be_n_q, be_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_done_q, wr_done_d;

    logic              accept;

    assign accept = req_valid && (state_q == IDLE);

    // Sequencing: request fields are captured once at acceptance and held for the access.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d  = CNT_LOAD;
                    addr_d = req_addr;
                    if (req_write) begin
                        state_d = W_SETUP;
                        wdata_d = req_wdata;
                        be_d    = req_be;
                    end else begin
                        state_d = R_WAIT;
                    end
                end
            end
            W_SETUP: state_d = W_PULSE;
            W_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = W_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            W_HOLD: state_d = IDLE;
            R_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = R_DONE;
                    rd_data_d = sram_dq_in;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            R_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every output leaves a flop.
    always_comb begin
        ready_d    = 1'b0;
        ce_n_d     = 1'b1;
        we_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        be_n_d     = '1;
        dq_oe_d    = 1'b0;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;
        unique case (state_d)
            IDLE: ready_d = 1'b1;
            W_SETUP: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~be_d;
                dq_oe_d = 1'b1;
            end
            W_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~be_d;
                dq_oe_d = 1'b1;
            end
            W_HOLD: begin
                ce_n_d    = 1'b0;
                be_n_d    = ~be_d;
                dq_oe_d   = 1'b1;
                wr_done_d = 1'b1;
            end
            R_WAIT: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            R_DONE:  rd_valid_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    // Asynchronous reset drops every strobe at once, aborting any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            ready_q    <= 1'b1;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            be_n_q     <= '1;
            dq_oe_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            ready_q    <= ready_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            be_n_q     <= be_n_d;
            dq_oe_q    <= dq_oe_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign req_ready   = ready_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign wr_done     = wr_done_q;
    assign sram_addr   = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_be_n   = be_n_q;
    assign sram_dq_out = wdata_q;
    assign sram_dq_oe  = dq_oe_q;

endmodule

// File: doc/async_sram_ctrl.md
Name: async_sram_ctrl

Overview:
- Synchronous front-end controller for an external asynchronous SRAM; successor to the single-width, fixed-timing sram block.
- Accepts single-word read/write requests over a valid/ready handshake and sequences the ce_n/we_n/oe_n/be_n strobes with parametrised setup, pulse and hold timing.
- Returns read data with a one-cycle valid pulse. Sits between a bus master and the SRAM pins; the top level owns the dq tristate buffer.

Parameters:
ADDR_W, 8, SRAM address width in bits.
DATA_W, 16, data width in bits; must be a multiple of 8.
WAIT_CYCLES, 2, clock cycles of the we_n low pulse and of the read access wait; minimum 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request; high only in IDLE.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  word address.
req_wdata  input  DATA_W  write data.
req_be  input  DATA_W/8  byte-lane write enables, active high; ignored on reads.
rd_data  output  DATA_W  registered read data.
rd_valid  output  1  one-cycle pulse when rd_data is valid.
wr_done  output  1  one-cycle pulse when a write completes.
sram_addr  output  ADDR_W  address to the SRAM pins.
sram_ce_n  output  1  chip enable, active low.
sram_we_n  output  1  write enable, active low.
sram_oe_n  output  1  output enable, active low.
sram_be_n  output  DATA_W/8  byte-lane enables, active low.
sram_dq_out  output  DATA_W  write data to the tristate buffer.
sram_dq_oe  output  1  1 = controller drives dq.
sram_dq_in  input  DATA_W  data sampled from the dq pins.

Behaviour:
- Reset (reset = 0, applied asynchronously):
  - state = IDLE; sram_ce_n, sram_we_n and sram_oe_n = 1; sram_be_n = all 1; sram_dq_oe = 0.
  - rd_valid and wr_done = 0; rd_data, sram_addr and sram_dq_out = 0; wait counter = 0.
  - A reset asserted mid-access deasserts all strobes immediately. The aborted access produces no rd_valid or wr_done.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT, R_DONE.
  - All pin outputs are registered.
  - Request fields are latched on acceptance (req_valid & req_ready) and are not resampled during the access.
- IDLE:
  - req_ready = 1; all strobes inactive; dq_oe = 0. IDLE also serves as the bus-turnaround cycle.
  - On acceptance: go to W_SETUP if req_write, else R_WAIT. The wait counter loads WAIT_CYCLES-1.
- W_SETUP (1 cycle): sram_addr and dq_out valid; dq_oe = 1; ce_n = 0; be_n = ~req_be; we_n = 1; oe_n = 1.
- W_PULSE (WAIT_CYCLES cycles): as W_SETUP but we_n = 0. Counter decrements each cycle; at 0 go to W_HOLD.
- W_HOLD (1 cycle):
  - we_n = 1; ce_n = 0; dq_oe = 1; addr and data held; wr_done = 1.
  - Then go to IDLE, where ce_n = 1 and dq_oe = 0.
- R_WAIT (WAIT_CYCLES cycles): ce_n = 0; oe_n = 0; be_n = all 0; we_n = 1; dq_oe = 0. On the clock edge ending the last R_WAIT cycle, rd_data <= sram_dq_in.
- R_DONE (1 cycle): rd_valid = 1; ce_n = 1; oe_n = 1; be_n = all 1. Then go to IDLE.
- Latency:
  - Write occupies 2 + WAIT_CYCLES cycles after acceptance.
  - Read: rd_valid is high WAIT_CYCLES+1 cycles after acceptance.
  - Next acceptance is possible 1 cycle after the state returns to IDLE, i.e. back-to-back accesses are separated by one IDLE cycle.
- Invariants:
  - we_n and oe_n are never both low.
  - dq_oe = 1 implies oe_n = 1.
  - we_n falls only with address and data already stable for at least 1 cycle.
  - rd_data holds its value until the next read completes.
- Write with req_be = 0: the full strobe sequence still runs with be_n = all 1, and wr_done still pulses.
- Counter width: $clog2(WAIT_CYCLES+1). WAIT_CYCLES = 1 gives single-cycle W_PULSE and R_WAIT.
- req_valid deasserted while not ready: no effect. Requests are never dropped or reordered.

Test Plan:
- Write 24 to addr 28, then read addr 28 (WAIT_CYCLES=2) -> wr_done pulses 4 cycles after acceptance; rd_valid 3 cycles after read acceptance with rd_data=24.
- Overwrite addr 28 with 30, then read with req_wdata=26 held during the read -> rd_data=30, dq_oe=0 for the whole read.
- Write 0xABCD to addr 5 with be=2'b11, then write 0x1200 with be=2'b10, then read addr 5 -> rd_data=0x12CD; be_n=2'b01 during the second write.
- req_valid held high with alternating write/read to addrs 28 and 242 -> req_ready low for the whole access; one IDLE cycle between accesses; oe_n and we_n never simultaneously 0; no dq_oe overlap with oe_n=0.
- Assert reset during the second W_PULSE cycle -> ce_n, we_n, oe_n = 1 and dq_oe = 0 within the same cycle (asynchronous); no wr_done; req_ready=1 after release.
- Sweep WAIT_CYCLES=1 and 5 -> we_n low for exactly 1 and 5 cycles; read latency of 2 and 6 cycles respectively.
